// File: rtl/core_pkg.sv
// Shared fetch-side definitions: the NOP encoding and the fetch FSM state type.
package core_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_st_e;

endpackage

// File: rtl/inst_fetch.sv
// Fetch stage: samples the free-running PC, drives a 1-cycle-latency ROM and owns the IF/ID
// register. Because the PC cannot stall, an ID hold is bridged by redirecting the PC back.
//
// Handshake: there is no valid/ready pair toward ID. ID asserts hold_i to keep the current
// IF/ID contents, and an instruction counts as accepted in any cycle where inst_valid_o=1 and
// hold_i=0. redirect_o is a single-cycle request with no acknowledge: the PC must load
// redirect_addr_o on the next edge.
module inst_fetch
    import core_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_INST)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pc_i,
    input  logic             jump_en_i,
    input  logic             hold_i,
    output logic [WIDTH-1:0] rom_addr_o,
    input  logic [WIDTH-1:0] rom_data_i,
    output logic [WIDTH-1:0] inst_o,
    output logic [WIDTH-1:0] inst_addr_o,
    output logic             inst_valid_o,
    output logic             redirect_o,
    output logic [WIDTH-1:0] redirect_addr_o,
    output logic             fsm_state
);

    fetch_st_e        state;
    fetch_st_e        state_n;
    logic [WIDTH-1:0] s1_addr;
    logic             s1_vld;
    logic [WIDTH-1:0] resume_addr;
    logic             advance;
    logic             enter_hold;
    logic             redirect;

    assign rom_addr_o      = pc_i;
    assign redirect_o      = redirect;
    assign redirect_addr_o = resume_addr;
    assign fsm_state       = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    // A jump overrides everything, including a pending hold release.
    always_comb begin
        state_n    = state;
        advance    = 1'b0;
        enter_hold = 1'b0;
        redirect   = 1'b0;
        if (jump_en_i) begin
            state_n = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (hold_i) begin
                        state_n    = HOLD;
                        enter_hold = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
                HOLD: begin
                    if (!hold_i) begin
                        state_n  = RUN;
                        redirect = 1'b1;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_addr      <= '0;
            s1_vld       <= 1'b0;
            resume_addr  <= '0;
            inst_o       <= NOP;
            inst_addr_o  <= '0;
            inst_valid_o <= 1'b0;
        end else if (jump_en_i || redirect) begin
            s1_vld       <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_o       <= NOP;
        end else if (advance) begin
            s1_addr      <= pc_i;
            s1_vld       <= 1'b1;
            inst_o       <= s1_vld ? rom_data_i : NOP;
            inst_addr_o  <= s1_addr;
            inst_valid_o <= s1_vld;
        end else if (enter_hold) begin
            // The oldest address not yet in IF/ID is where the PC must resume.
            resume_addr <= s1_vld ? s1_addr : pc_i;
            s1_vld      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a PC/ROM model around the DUT, hand-written expected fetch
// stream in a queue, and a monitor that checks every instruction ID accepts.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_i;
    logic        jump_en_i;
    logic        hold_i;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        redirect_o;
    logic [31:0] redirect_addr_o;
    logic        fsm_state;

    int checks;
    int failures;
    logic [31:0] exp_q[$];

    inst_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_i            (pc_i),
        .jump_en_i       (jump_en_i),
        .hold_i          (hold_i),
        .rom_addr_o      (rom_addr_o),
        .rom_data_i      (rom_data_i),
        .inst_o          (inst_o),
        .inst_addr_o     (inst_addr_o),
        .inst_valid_o    (inst_valid_o),
        .redirect_o      (redirect_o),
        .redirect_addr_o (redirect_addr_o),
        .fsm_state       (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'hABCD_0000;
    endfunction

    always @(posedge clk) rom_data_i <= rom_word(rom_addr_o);

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (inst_valid_o && !hold_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_inst: got addr %h expected none", inst_addr_o);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("stream_addr", inst_addr_o, e);
                    chk("stream_data", inst_o, rom_word(e));
                end
            end else if (!inst_valid_o) begin
                chk("invalid_is_nop", inst_o, NOP);
            end
        end
    end

    // driver: one cycle of control inputs, samples outputs mid-cycle, models the PC
    logic        s_v;
    logic [31:0] s_a;
    logic        s_r;
    logic [31:0] s_ra;

    task automatic step(input logic jmp, input logic [31:0] tgt, input logic hld);
        jump_en_i = jmp;
        hold_i    = hld;
        @(negedge clk);
        s_v  = inst_valid_o;
        s_a  = inst_addr_o;
        s_r  = redirect_o;
        s_ra = redirect_addr_o;
        @(posedge clk);
        #1;
        if (jmp)      pc_i = tgt;
        else if (s_r) pc_i = s_ra;
        else          pc_i = pc_i + 32'd4;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_inst"}, inst_o, NOP);
        chk({tag, "_addr"}, inst_addr_o, 32'h0);
        chk({tag, "_valid"}, {31'h0, inst_valid_o}, 32'h0);
        chk({tag, "_redirect"}, {31'h0, redirect_o}, 32'h0);
        chk({tag, "_redirect_addr"}, redirect_addr_o, 32'h0);
        chk({tag, "_state"}, {31'h0, fsm_state}, 32'h0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        pc_i      = 32'h0;
        jump_en_i = 1'b0;
        hold_i    = 1'b0;
        exp_q = '{32'h00, 32'h04, 32'h08, 32'h40, 32'h44, 32'h80, 32'h84,
                  32'hC0, 32'hC4, 32'hC8, 32'hCC, 32'h00, 32'h04};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // sequential fetch: valid rises two cycles after the first PC
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk("first_slot_invalid", {31'h0, s_v}, 32'h0);
        step(1'b0, 32'h0, 1'b0);
        chk("first_valid", {31'h0, s_v}, 32'h1);
        chk("first_addr", s_a, 32'h0);

        // hold for three cycles with 0x08 in S1
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1);
            chk("hold_frozen_addr", s_a, 32'h04);
            chk("hold_no_redirect", {31'h0, s_r}, 32'h0);
        end
        step(1'b0, 32'h0, 1'b0);
        chk("release_redirect", {31'h0, s_r}, 32'h1);
        chk("release_redirect_addr", s_ra, 32'h08);
        step(1'b0, 32'h0, 1'b0);
        chk("redirect_single_cycle", {31'h0, s_r}, 32'h0);
        chk("bubble1", {31'h0, s_v}, 32'h0);
        step(1'b0, 32'h0, 1'b0);
        chk("bubble2", {31'h0, s_v}, 32'h0);

        // jump with PC=0x10 to 0x40; 0x08 arrives in the same cycle
        chk("pc_at_jump", pc_i, 32'h10);
        step(1'b1, 32'h40, 1'b0);
        chk("resume_addr_08", s_a, 32'h08);
        step(1'b0, 32'h0, 1'b0);
        chk("jump_slot1", {31'h0, s_v}, 32'h0);
        step(1'b0, 32'h0, 1'b0);
        chk("jump_slot2", {31'h0, s_v}, 32'h0);
        step(1'b0, 32'h0, 1'b0);
        chk("jump_target", s_a, 32'h40);
        chk("jump_target_valid", {31'h0, s_v}, 32'h1);
        run(1);

        // hold and jump together in RUN
        step(1'b1, 32'h80, 1'b1);
        chk("hold_jump_no_redirect", {31'h0, s_r}, 32'h0);
        run(2);
        chk("hold_jump_state", {31'h0, fsm_state}, 32'h0);
        step(1'b0, 32'h0, 1'b0);
        chk("hold_jump_target", s_a, 32'h80);

        // jump on the hold-release cycle
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'hC0, 1'b0);
        chk("release_jump_no_redirect", {31'h0, s_r}, 32'h0);
        run(2);
        chk("release_jump_bubble", {31'h0, s_v}, 32'h0);
        step(1'b0, 32'h0, 1'b0);
        chk("release_jump_target", s_a, 32'hC0);
        run(1);

        // hold toggling 1->0->1->0
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        chk("toggle_redirect1", {31'h0, s_r}, 32'h1);
        chk("toggle_redirect1_addr", s_ra, 32'hCC);
        step(1'b0, 32'h0, 1'b1);
        chk("toggle_fresh_hold", {31'h0, s_r}, 32'h0);
        step(1'b0, 32'h0, 1'b0);
        chk("toggle_redirect2", {31'h0, s_r}, 32'h1);
        chk("toggle_redirect2_addr", s_ra, 32'hCC);
        step(1'b0, 32'h0, 1'b0);
        chk("toggle_no_repeat", {31'h0, s_r}, 32'h0);
        run(1);
        step(1'b0, 32'h0, 1'b0);
        chk("toggle_resume", s_a, 32'hCC);

        // async reset while in HOLD
        step(1'b0, 32'h0, 1'b1);
        hold_i = 1'b1;
        @(negedge clk);
        chk("pre_reset_state_hold", {31'h0, fsm_state}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        hold_i = 1'b0;
        pc_i   = 32'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b0);
        chk("post_reset_no_redirect", {31'h0, s_r}, 32'h0);
        chk("post_reset_state", {31'h0, fsm_state}, 32'h0);
        run(3);
        chk("post_reset_stream", s_a, 32'h04);

        // park with ID held so nothing further is accepted
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1);
            chk("park_no_redirect", {31'h0, s_r}, 32'h0);
        end
        chk("queue_drained", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
